// File: rtl/const_pkg.sv
// Shared single-bit flag constants so flag assignments read as intent, not literals.
package const_pkg;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic VAL   = 1'b1;
  localparam logic INV   = 1'b0;
endpackage

// File: rtl/thor2022_bus_pkg.sv
// Thor2022 external-bus shared types; monitors decode arbiter state with arb_state_t.
package thor2022_bus_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    REL  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/thor2022_rr_sel.sv
// Combinational round-robin pick: first set req bit at index >= pointer, wrapping.
module thor2022_rr_sel
  import const_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic [NREQ-1:0] sel,
  output logic [IW-1:0]   index,
  output logic            any
);

  // Walk from farthest to nearest so the bit closest to pointer wins.
  always_comb begin
    int          j;
    logic [IW-1:0] jj;
    sel   = '0;
    index = '0;
    any   = |req;
    for (int k = NREQ-1; k >= 0; k--) begin
      j = int'(pointer) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (req[jj]) begin
        sel     = '0;
        sel[jj] = VAL;
        index   = jj;
      end
    end
  end

endmodule

// File: rtl/thor2022_bus_arbiter.sv
// Round-robin owner arbitration for the single Thor2022 external bus port,
// with lock hold, error/ack release, abandon detection and busy timeout.
module thor2022_bus_arbiter
  import const_pkg::*;
  import thor2022_bus_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int TMO_BITS = 10,
  localparam int IW       = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] lock_i,
  input  logic            ack_i,
  input  logic            err_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   gnt_num_o,
  output logic            gnt_vld_o,
  output logic            tmo_o
);

  arb_state_t          state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]       num_q, num_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [TMO_BITS-1:0] cnt_q, cnt_d;
  logic                tmo_q, tmo_d;

  logic [NREQ-1:0] pick_sel;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            rel;

  thor2022_rr_sel #(.NREQ(NREQ)) u_rr_sel (
    .req     (req_i),
    .pointer (ptr_q),
    .sel     (pick_sel),
    .index   (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      num_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= FALSE;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      num_q   <= num_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    num_d   = num_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = FALSE;
    rel     = FALSE;
    case (state_q)
      IDLE: if (pick_any) begin
        gnt_d   = pick_sel;
        num_d   = pick_idx;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        // Error and timeout override lock; completion beats a same-cycle timeout.
        if (err_i)                                  rel = TRUE;
        else if (ack_i && lock_i[num_q])            cnt_d = '0;
        else if (ack_i)                             rel = TRUE;
        else if (!req_i[num_q] && !lock_i[num_q])   rel = TRUE;
        else if (cnt_q == '1) begin
          rel   = TRUE;
          tmo_d = TRUE;
        end else                                    cnt_d = cnt_q + 1'b1;
        if (rel) begin
          gnt_d   = '0;
          ptr_d   = (num_q == IW'(NREQ-1)) ? '0 : num_q + 1'b1;
          state_d = REL;
        end
      end
      REL:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o     = gnt_q;
  assign gnt_num_o = num_q;
  assign gnt_vld_o = |gnt_q;
  assign tmo_o     = tmo_q;

endmodule

// File: tb/tb_thor2022_bus_arbiter.sv
// Directed + randomized check of the bus arbiter against an owner-level reference model.
module tb_thor2022_bus_arbiter;
  localparam int NREQ = 4;
  localparam int TMO_BITS = 4;
  localparam int TMO_MAX = (1 << TMO_BITS) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req, lock;
  logic            ack, err;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_num;
  logic            gnt_vld, tmo;

  int tests = 0;
  int fails = 0;

  // reference model: who owns the bus, how long, and whether a dead cycle is pending
  int m_owner, m_last, m_ptr, m_cnt, m_cool;
  bit m_tmo;

  thor2022_bus_arbiter #(.NREQ(NREQ), .TMO_BITS(TMO_BITS)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .ack_i(ack), .err_i(err),
    .gnt_o(gnt), .gnt_num_o(gnt_num), .gnt_vld_o(gnt_vld), .tmo_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_release(input bit by_tmo);
    m_ptr   = (m_owner + 1) % NREQ;
    m_owner = -1;
    m_cool  = 1;
    m_tmo   = by_tmo;
  endtask

  task automatic model_step();
    bit found;
    if (rst) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_cnt = 0; m_cool = 0; m_tmo = 0;
      return;
    end
    m_tmo = 0;
    if (m_owner >= 0) begin
      if (err)                                    model_release(0);
      else if (ack && lock[m_owner])              m_cnt = 0;
      else if (ack)                               model_release(0);
      else if (!req[m_owner] && !lock[m_owner])   model_release(0);
      else if (m_cnt == TMO_MAX)                  model_release(1);
      else                                        m_cnt++;
    end else if (m_cool > 0) begin
      m_cool = 0;
    end else begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (!found && req[c]) begin
          found = 1; m_owner = c; m_last = c; m_cnt = 0;
        end
      end
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare off-edge.
  task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                     input logic a, input logic e, input logic rs);
    logic [NREQ-1:0] exp_gnt;
    req = r; lock = l; ack = a; err = e; rst = rs;
    @(posedge clk);
    model_step();
    #1;
    exp_gnt = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
    chk("model_gnt", gnt, exp_gnt);
    chk("model_num", gnt_num, m_last);
    chk("model_vld", gnt_vld, m_owner >= 0);
    chk("model_tmo", tmo, m_tmo);
    chk("vld_is_or", gnt_vld, |gnt);
    chk("onehot", $countones(gnt) <= 1, 1);
  endtask

  int exp_seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    m_owner = -1; m_last = 0; m_ptr = 0; m_cnt = 0; m_cool = 0; m_tmo = 0;

    // reset and single request, release moves pointer to 3
    cyc(4'b0000, 4'b0000, 0, 0, 1);
    cyc(4'b0000, 4'b0000, 0, 0, 1);
    chk("rst_gnt", gnt, 0); chk("rst_num", gnt_num, 0);
    chk("rst_vld", gnt_vld, 0); chk("rst_tmo", tmo, 0);
    repeat (2) cyc(4'b0000, 4'b0000, 0, 0, 0);
    cyc(4'b0100, 4'b0000, 0, 0, 0);
    chk("t1_gnt", gnt, 4'b0100); chk("t1_num", gnt_num, 2);
    cyc(4'b0100, 4'b0000, 0, 0, 0);
    cyc(4'b0100, 4'b0000, 0, 0, 0);
    cyc(4'b0100, 4'b0000, 1, 0, 0);
    chk("t1_rel", gnt, 0);
    cyc(4'b1111, 4'b0000, 0, 0, 0);
    cyc(4'b1111, 4'b0000, 0, 0, 0);
    chk("t1_ptr3", gnt_num, 3); chk("t1_ptr3_gnt", gnt, 4'b1000);

    // round robin with all requesting
    cyc(4'b0000, 4'b0000, 0, 0, 1);
    cyc(4'b1111, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("rr_num", gnt_num, exp_seq[i]); chk("rr_vld", gnt_vld, 1);
      cyc(4'b1111, 4'b0000, 0, 0, 0);
      cyc(4'b1111, 4'b0000, 1, 0, 0);
      chk("rr_rel_gap", gnt_vld, 0);
      cyc(4'b1111, 4'b0000, 0, 0, 0);
      chk("rr_idle_gap", gnt_vld, 0);
      cyc(4'b1111, 4'b0000, 0, 0, 0);
    end

    // locked sequence: three acks keep the grant, fourth after unlock releases
    cyc(4'b0000, 4'b0000, 0, 0, 1);
    cyc(4'b0010, 4'b0010, 0, 0, 0);
    chk("lk_gnt", gnt, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1010, 4'b0010, 0, 0, 0);
      cyc(4'b1010, 4'b0010, 1, 0, 0);
      chk("lk_hold", gnt, 4'b0010);
    end
    cyc(4'b1010, 4'b0000, 0, 0, 0);
    chk("lk_unlock_hold", gnt, 4'b0010);
    cyc(4'b1010, 4'b0000, 1, 0, 0);
    chk("lk_rel", gnt, 0);
    cyc(4'b1000, 4'b0000, 0, 0, 0);
    cyc(4'b1000, 4'b0000, 0, 0, 0);
    chk("lk_next", gnt, 4'b1000);

    // timeout, then same length with ack on the last counted cycle
    cyc(4'b0000, 4'b0000, 0, 0, 1);
    cyc(4'b0001, 4'b0000, 0, 0, 0);
    chk("to_gnt", gnt, 4'b0001);
    repeat (TMO_MAX) cyc(4'b0001, 4'b0000, 0, 0, 0);
    chk("to_still", gnt, 4'b0001); chk("to_no_tmo_yet", tmo, 0);
    cyc(4'b0001, 4'b0000, 0, 0, 0);
    chk("to_rel", gnt, 0); chk("to_tmo", tmo, 1);
    cyc(4'b0000, 4'b0000, 0, 0, 0);
    chk("to_tmo_pulse", tmo, 0);
    cyc(4'b0001, 4'b0000, 0, 0, 0);
    chk("to2_gnt", gnt, 4'b0001);
    repeat (TMO_MAX) cyc(4'b0001, 4'b0000, 0, 0, 0);
    cyc(4'b0001, 4'b0000, 1, 0, 0);
    chk("to2_rel", gnt, 0); chk("to2_no_tmo", tmo, 0);
    cyc(4'b0000, 4'b0000, 0, 0, 0);
    chk("to2_no_tmo_b", tmo, 0);

    // error overrides lock, pointer moves to 3
    cyc(4'b0000, 4'b0000, 0, 0, 1);
    cyc(4'b0100, 4'b0100, 0, 0, 0);
    chk("er_gnt", gnt, 4'b0100);
    cyc(4'b0100, 4'b0100, 0, 0, 0);
    cyc(4'b0100, 4'b0100, 0, 1, 0);
    chk("er_rel", gnt, 0); chk("er_no_tmo", tmo, 0);
    cyc(4'b1011, 4'b0000, 0, 0, 0);
    cyc(4'b1011, 4'b0000, 0, 0, 0);
    chk("er_ptr3", gnt_num, 3); chk("er_gnt3", gnt, 4'b1000);

    // reset mid-transfer
    cyc(4'b1011, 4'b0000, 0, 0, 1);
    chk("rb_gnt", gnt, 0); chk("rb_num", gnt_num, 0);
    chk("rb_vld", gnt_vld, 0); chk("rb_tmo", tmo, 0);
    cyc(4'b1111, 4'b0000, 0, 0, 0);
    chk("rb_first", gnt, 4'b0001);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [NREQ-1:0] r, l;
      r = NREQ'($urandom);
      l = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
      cyc(r, l, $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
          $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
